branch_resolve_ctrl: RTL and testbench

- Sequences ID-stage branch resolution for the MIPS pipeline.
- Holds a decoded branch until its operands are forwarded, then samples the equality/sign comparator result.
- On a taken branch, issues one PC redirect to fetch, but only after the delay-slot instruction has been fetched, because AXI fetch can miss.
- Sits between the decode stage, the hazard unit, the branch comparator and the IF redirect port.

---
 rtl/branch_resolve_ctrl.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: waits for operands, samples the comparator, and issues one
// fetch redirect after the delay slot is in IF. Define BRANCH_STATS_EN to add statistics counters.
module branch_resolve_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            br_valid_i,
    input  logic [5:0]      br_op_i,
    input  logic [4:0]      br_rt_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            opnd_ready_i,
    input  logic            cmp_y_i,
    input  logic            ds_valid_i,
    input  logic            redirect_ack_i,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic            taken_o,
    output logic            link_o,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
`endif
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT_OPND, DS_WAIT, REDIRECT} state_e;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    state_e          state_q, state_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            link_flag_q, link_flag_d;
    logic            taken_q, taken_d;
    logic            link_q, link_d;
    logic            is_branch, is_link, resolve;

    always_comb begin : decode
        is_branch = 1'b0;
        is_link   = 1'b0;
        if (br_valid_i) begin
            case (br_op_i)
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
                OP_REGIMM: begin
                    case (br_rt_i)
                        RT_BLTZ, RT_BGEZ: is_branch = 1'b1;
                        RT_BLTZAL, RT_BGEZAL: begin
                            is_branch = 1'b1;
                            is_link   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin : next_state
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        target_d    = target_q;
        link_flag_d = link_flag_q;
        taken_d     = 1'b0;
        link_d      = 1'b0;
        resolve     = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_branch) begin
                    target_d    = br_target_i;
                    link_flag_d = is_link;
                    if (opnd_ready_i) begin
                        resolve = 1'b1;
                        link_d  = is_link;
                    end else begin
                        state_d = WAIT_OPND;
                    end
                end
            end
            WAIT_OPND: begin
                if (opnd_ready_i) begin
                    resolve = 1'b1;
                    link_d  = link_flag_q;
                end
            end
            DS_WAIT:  if (ds_valid_i) state_d = REDIRECT;
            REDIRECT: if (redirect_ack_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (resolve) begin
            taken_d = cmp_y_i;
            if (!cmp_y_i)       state_d = IDLE;
            else if (ds_valid_i) state_d = REDIRECT;
            else                 state_d = DS_WAIT;
        end

        // Flush drops any in-flight or simultaneously presented branch.
        if (flush_i) begin
            state_d     = IDLE;
            target_d    = '0;
            link_flag_d = 1'b0;
            taken_d     = 1'b0;
            link_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            link_flag_q <= 1'b0;
            taken_q     <= 1'b0;
            link_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            link_flag_q <= link_flag_d;
            taken_q     <= taken_d;
            link_q      <= link_d;
        end
    end

    assign stall_o          = (state_q == WAIT_OPND) || (state_q == DS_WAIT);
    assign redirect_valid_o = (state_q == REDIRECT);
    assign redirect_pc_o    = target_q;
    assign taken_o          = taken_q;
    assign link_o           = link_q;
    assign busy_o           = (state_q != IDLE);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, taken_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (resolve && !flush_i) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
                if (cmp_y_i) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
            if (stall_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: decode table, directed corner sequences,
// and randomized traffic against a behavioural model (counters checked when BRANCH_STATS_EN is set).
module tb_branch_resolve_ctrl;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            rst, flush_i, br_valid_i, opnd_ready_i, cmp_y_i, ds_valid_i, redirect_ack_i;
    logic [5:0]      br_op_i;
    logic [4:0]      br_rt_i;
    logic [PC_W-1:0] br_target_i;
    logic            stall_o, redirect_valid_o, taken_o, link_o, busy_o;
    logic [PC_W-1:0] redirect_pc_o;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_o, taken_cnt_o, stall_cnt_o;
`endif
    logic [4:0]      st;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .br_valid_i(br_valid_i),
        .br_op_i(br_op_i), .br_rt_i(br_rt_i), .br_target_i(br_target_i),
        .opnd_ready_i(opnd_ready_i), .cmp_y_i(cmp_y_i), .ds_valid_i(ds_valid_i),
        .redirect_ack_i(redirect_ack_i), .stall_o(stall_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .taken_o(taken_o), .link_o(link_o),
`ifdef BRANCH_STATS_EN
        .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
        .busy_o(busy_o)
    );

    // Status vector: {stall, redirect_valid, taken, link, busy}
    assign st = {stall_o, redirect_valid_o, taken_o, link_o, busy_o};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rt,
                         input logic [31:0] tgt, input logic rdy, input logic cy,
                         input logic ds, input logic ack, input logic fl);
        br_valid_i = v;  br_op_i = op;    br_rt_i = rt;      br_target_i = tgt;
        opnd_ready_i = rdy; cmp_y_i = cy; ds_valid_i = ds;   redirect_ack_i = ack;
        flush_i = fl;
    endtask

    task automatic quiet();
        drive(1'b0, 6'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference decode: {is_branch, is_link} from the MIPS branch encodings.
    function automatic logic [1:0] classify(input logic [5:0] op, input logic [4:0] rt);
        if (op inside {6'd4, 6'd5, 6'd6, 6'd7})           return 2'b10;
        if (op == 6'd1 && rt inside {5'd0, 5'd1})         return 2'b10;
        if (op == 6'd1 && rt inside {5'd16, 5'd17})       return 2'b11;
        return 2'b00;
    endfunction

    typedef struct {
        logic       valid;
        logic [5:0] op;
        logic [4:0] rt;
        logic       cmp;
        logic       exp_br;
        logic       exp_link;
    } vec_t;

    vec_t vecs[12];

    // Behavioural model state for the random phase.
    bit          m_hold, m_ds, m_redir, m_link, e_taken, e_link;
    logic [31:0] m_target;
    int          m_br_cnt, m_taken_cnt, m_stall_cnt;

    initial begin
        vecs[0]  = '{1'b1, 6'b000100, 5'b00000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 6'b000101, 5'b11111, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 6'b000110, 5'b00000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 6'b000111, 5'b00000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 6'b000001, 5'b00000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 6'b000001, 5'b00001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 6'b000001, 5'b10000, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 6'b000001, 5'b10001, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 6'b000001, 5'b00010, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 6'b000010, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'b000100, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 6'b000001, 5'b10000, 1'b0, 1'b1, 1'b1};

        quiet();
        rst = 1'b1;
        tick();
        tick();
        check("reset_status", st, 5'b0);
        check("reset_pc", redirect_pc_o, 32'd0);
`ifdef BRANCH_STATS_EN
        check("reset_cnts", {br_cnt_o, taken_cnt_o, stall_cnt_o}, '0);
`endif
        rst = 1'b0;

        // Decode table: ready operands, delay slot present, one cycle then ack.
        for (int i = 0; i < 12; i++) begin
            logic [31:0] tgt;
            logic        tk;
            tgt = 32'h8000_0000 + 32'(i) * 32'h10;
            tk  = vecs[i].exp_br & vecs[i].cmp;
            drive(vecs[i].valid, vecs[i].op, vecs[i].rt, tgt, 1'b1, vecs[i].cmp, 1'b1, 1'b0, 1'b0);
            tick();
            quiet();
            check($sformatf("vec%0d_status", i), st, {1'b0, tk, tk, vecs[i].exp_link, tk});
            if (vecs[i].exp_br) check($sformatf("vec%0d_pc", i), redirect_pc_o, tgt);
            redirect_ack_i = 1'b1;
            tick();
            quiet();
            check($sformatf("vec%0d_idle", i), st, 5'b0);
        end

        // BEQ taken, operands ready, delay slot present.
        drive(1'b1, 6'b000100, 5'd0, 32'hBFC0_0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        quiet();
        check("beq_taken", st, 5'b01101);
        check("beq_pc", redirect_pc_o, 32'hBFC0_0100);
        tick();
        check("beq_hold", st, 5'b01001);
        check("beq_hold_pc", redirect_pc_o, 32'hBFC0_0100);
        redirect_ack_i = 1'b1;
        tick();
        quiet();
        check("beq_done", st, 5'b0);

        // BNE with operands late for 3 cycles; a new branch in ID meanwhile is ignored.
        drive(1'b1, 6'b000101, 5'd0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("bne_wait0", st, 5'b10001);
        drive(1'b1, 6'b000100, 5'd0, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            tick();
            check($sformatf("bne_wait%0d", i), st, 5'b10001);
        end
        drive(1'b0, 6'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        quiet();
        check("bne_resolved", st, 5'b0);

        // BGEZAL not taken: link pulses alone.
        drive(1'b1, 6'b000001, 5'b10001, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        quiet();
        check("bgezal_link", st, 5'b00010);
        tick();
        check("bgezal_after", st, 5'b0);

        // BGTZ taken with the delay slot missing for 4 cycles, then a slow ack.
        drive(1'b1, 6'b000111, 5'd0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        quiet();
        check("bgtz_ds0", st, 5'b10101);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("bgtz_ds%0d", i), st, 5'b10001);
        end
        ds_valid_i = 1'b1;
        tick();
        ds_valid_i = 1'b0;
        check("bgtz_redirect", st, 5'b01001);
        check("bgtz_pc", redirect_pc_o, 32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("bgtz_hold%0d", i), st, 5'b01001);
            check($sformatf("bgtz_pc_hold%0d", i), redirect_pc_o, 32'h1234_5678);
        end
        redirect_ack_i = 1'b1;
        tick();
        quiet();
        check("bgtz_done", st, 5'b0);

        // Flush in WAIT_OPND with a concurrent BEQ.
        drive(1'b1, 6'b000101, 5'd0, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("flushw_wait", st, 5'b10001);
        drive(1'b1, 6'b000100, 5'd0, 32'h0000_5000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        quiet();
        check("flushw_status", st, 5'b0);
        check("flushw_pc", redirect_pc_o, 32'd0);
        tick();
        check("flushw_dropped", st, 5'b0);

        // Flush in REDIRECT with a concurrent BEQ.
        drive(1'b1, 6'b000100, 5'd0, 32'h0000_6000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("flushr_redirect", st, 5'b01101);
        drive(1'b1, 6'b000100, 5'd0, 32'h0000_7000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        quiet();
        check("flushr_status", st, 5'b0);
        check("flushr_pc", redirect_pc_o, 32'd0);
        tick();
        check("flushr_dropped", st, 5'b0);

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 6'b000100, 5'd0, 32'h0000_8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            quiet();
            redirect_ack_i = 1'b1;
            tick();
            quiet();
        end
        check("stats_br_wrap", br_cnt_o, 4'd1);
        check("stats_taken_wrap", taken_cnt_o, 4'd1);
        check("stats_stall", stall_cnt_o, 4'd0);
        drive(1'b1, 6'b000100, 5'd0, 32'h0000_9000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        quiet();
        check("stats_redirect", st, 5'b01101);
        rst = 1'b1;
        tick();
        check("stats_rst_status", st, 5'b0);
        check("stats_rst_pc", redirect_pc_o, 32'd0);
        check("stats_rst_cnts", {br_cnt_o, taken_cnt_o, stall_cnt_o}, '0);
        rst = 1'b0;
`endif

        // Randomized traffic against the model.
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hold = 0; m_ds = 0; m_redir = 0; m_link = 0; m_target = '0;
        m_br_cnt = 0; m_taken_cnt = 0; m_stall_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic [5:0]  op;
            logic [4:0]  rt;
            logic [1:0]  cls;
            logic [31:0] tgt;
            logic        v, rdy, cy, ds, ack, fl;
            bit          have;
            int          sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 4)      op = 6'(4 + sel);
            else if (sel < 6) op = 6'd1;
            else              op = 6'($urandom);
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: rt = 5'd0;
                1: rt = 5'd1;
                2: rt = 5'd16;
                3: rt = 5'd17;
                default: rt = 5'($urandom);
            endcase
            tgt = $urandom;
            v   = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) == 1;
            cy  = $urandom_range(0, 1) == 1;
            ds  = $urandom_range(0, 1) == 1;
            ack = $urandom_range(0, 1) == 1;
            fl  = ($urandom_range(0, 15) == 0);
            drive(v, op, rt, tgt, rdy, cy, ds, ack, fl);

            if (m_hold || m_ds) m_stall_cnt++;
            cls = v ? classify(op, rt) : 2'b00;
            e_taken = 0;
            e_link  = 0;
            if (fl) begin
                m_hold = 0; m_ds = 0; m_redir = 0; m_link = 0; m_target = '0;
            end else if (m_redir) begin
                if (ack) m_redir = 0;
            end else if (m_ds) begin
                if (ds) begin
                    m_ds = 0;
                    m_redir = 1;
                end
            end else begin
                have = m_hold;
                if (!m_hold && cls[1]) begin
                    have = 1;
                    m_target = tgt;
                    m_link = cls[0];
                end
                if (have) begin
                    if (rdy) begin
                        m_hold  = 0;
                        e_taken = cy;
                        e_link  = m_link;
                        m_br_cnt++;
                        if (cy) begin
                            m_taken_cnt++;
                            if (ds) m_redir = 1;
                            else    m_ds = 1;
                        end
                    end else begin
                        m_hold = 1;
                    end
                end
            end

            tick();
            check($sformatf("rand%0d_status", c), st,
                  {m_hold | m_ds, m_redir, e_taken, e_link, m_hold | m_ds | m_redir});
            check($sformatf("rand%0d_pc", c), redirect_pc_o, m_target);
        end
        quiet();
`ifdef BRANCH_STATS_EN
        check("rand_br_cnt", br_cnt_o, 64'(m_br_cnt % (1 << CNT_W)));
        check("rand_taken_cnt", taken_cnt_o, 64'(m_taken_cnt % (1 << CNT_W)));
        check("rand_stall_cnt", stall_cnt_o, 64'(m_stall_cnt % (1 << CNT_W)));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
